rf_write_sched: RTL and testbench
=================================

Name: rf_write_sched

Overview:
- Write-port scheduler for the 16 x 8-bit register file (R0 = accumulator, R1..R15 general, plus the 10-bit branch register).
- Arbitrates three producers onto the file's single write path:
  - accumulator writeback (ACC)
  - general-register writeback (GEN)
  - LUT branch-target load (BR)
- Drives the file's WriteR0 / GenRegWrite / LUTsignal strobes, address, data and target.
- After every reset, sequences a zero-clear sweep of all registers before accepting producer traffic.

Parameters:
- NUM_REGS, 16, register count; address width is $clog2(NUM_REGS).
- DW, 8, register data width.
- TW, 10, branch target width.
- INIT_CLEAR, 1, 1 = run the post-reset clear sweep; 0 = go straight to ARB.

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- AccValid  in  1  ACC request
- AccData  in  DW  accumulator value
- AccReady  out  1  ACC accepted this cycle
- GenValid  in  1  GEN request
- GenAddr  in  4  destination register
- GenData  in  DW  value
- GenReady  out  1  GEN accepted this cycle
- BrValid  in  1  BR request
- BrTarget  in  TW  branch target
- BrReady  out  1  BR accepted this cycle
- WriteR0  out  1  regfile R0 write strobe
- GenRegWrite  out  1  regfile general write strobe
- LUTsignal  out  1  regfile branch-reg load strobe
- WAddr  out  4  regfile write address
- DataIn  out  DW  regfile write data
- Target  out  TW  regfile branch target
- InitDone  out  1  high once clear sweep complete

Behaviour:
- Reset (sampled at posedge while Reset=1):
  - all strobes 0, WAddr 0, DataIn 0, Target 0, all Ready 0, InitDone 0
  - state <= INIT (or ARB with InitDone=1 if INIT_CLEAR=0)
  - sweep counter <= 0
  - Reset mid-sweep or mid-grant aborts and restarts the sweep; no pending transfer survives.
- FSM states: INIT, ARB.
- INIT:
  - count 0 issues WriteR0=1, DataIn=0.
  - counts 1..NUM_REGS-1 issue GenRegWrite=1, WAddr=count, DataIn=0.
  - count NUM_REGS issues LUTsignal=1, Target=0.
  - Then state <= ARB, InitDone <= 1.
  - Sweep occupies NUM_REGS+1 cycles (17 at default); every Ready is 0 throughout.
- ARB, Ready generation:
  - Ready outputs are combinational from state and Valids.
  - At most one Ready is high per cycle.
  - Ready is asserted only to the winner, and only when its Valid=1.
- ARB, transfer and strobe timing:
  - A transfer occurs on a posedge with Valid&&Ready.
  - The corresponding strobe plus WAddr/DataIn/Target are registered and appear the following cycle for exactly one cycle.
  - Throughput is one write per cycle; back-to-back grants are allowed.
- ARB, idle cycles:
  - With no transfer, the next cycle's strobes are 0.
  - WAddr/DataIn/Target hold their last values.
- Fixed priority (default): BR > ACC > GEN.
- Producer rules:
  - Producers hold Valid and payload stable until Ready.
  - Deasserting Valid without Ready is legal; the request is dropped.
- Mapping:
  - ACC -> WriteR0, WAddr=0.
  - GEN with GenAddr!=0 -> GenRegWrite, WAddr=GenAddr.
  - GEN with GenAddr==0 -> WriteR0 (R0 always written via WriteR0 strobe).
  - BR -> LUTsignal; DataIn and WAddr unchanged.
- Invariants:
  - Exactly one of the three strobes is high, or none.
  - Never two in the same cycle, including during INIT.

Optional Feature:
- RF_WRITE_SCHED_RR_EN
- Defined: round-robin among BR/ACC/GEN.
  - A 2-bit last-grant pointer makes the most recently granted requester lowest priority next cycle.
  - Pointer reset value = BR (so ACC wins the first contention).
  - Pointer is unchanged in cycles with no transfer.
- Undefined: fixed BR > ACC > GEN; no pointer logic.

Decomposition:
- Package rf_sched_pkg:
  - typedef enum {INIT, ARB} sched_state_t
  - typedef enum {REQ_BR, REQ_ACC, REQ_GEN} req_id_t
  - localparams for DW, TW, NUM_REGS defaults
- One sub-module, rf_sched_arb: 3-way combinational grant (fixed, or round-robin with pointer under the macro) taking valids and pointer, returning one-hot grant.

Test Plan:
- Reset 5 cycles, release, all Valids high -> 17 sweep cycles:
  - WriteR0@c0, GenRegWrite WAddr 1..15, LUTsignal@c16, DataIn=0
  - Readies 0 throughout; InitDone=1 after
- After init: AccValid=1 AccData=13, GenValid=1 GenAddr=5 GenData=0x7E, BrValid=1 BrTarget=255 together ->
  - fixed priority: LUTsignal/Target=255, then WriteR0/DataIn=13, then GenRegWrite/WAddr=5/DataIn=0x7E, on 3 consecutive cycles
  - RR_EN: grant order ACC, GEN, BR with the same payloads
- GenValid=1 GenAddr=0 GenData=0x42 -> next cycle WriteR0=1, WAddr=0, DataIn=0x42, GenRegWrite=0.
- Reset asserted at sweep count 7 for 1 cycle -> strobes 0 next cycle; sweep restarts at count 0; InitDone stays 0 until 17 further cycles.
- AccValid held high continuously, GenValid=1 ->
  - fixed: GenReady never asserts
  - RR_EN: GenReady on alternate cycles
- Assertion every cycle: $onehot0({WriteR0,GenRegWrite,LUTsignal}) and $onehot0({AccReady,GenReady,BrReady}).

Source files
------------

// File: rtl/rf_sched_pkg.sv
// Shared types and default sizes for the register-file write-port scheduler.
package rf_sched_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int DW_DEF       = 8;
    localparam int TW_DEF       = 10;
    localparam int NUM_REQ      = 3;

    typedef enum logic {
        INIT,
        ARB
    } sched_state_t;

    // Values double as bit positions in the valid/grant vectors.
    typedef enum logic [1:0] {
        REQ_BR  = 2'd0,
        REQ_ACC = 2'd1,
        REQ_GEN = 2'd2
    } req_id_t;

endpackage

// File: rtl/rf_write_sched_if.sv
// Producer handshakes plus register-file write strobes for rf_write_sched.
interface rf_write_sched_if #(
    parameter int NUM_REGS = 16,
    parameter int DW       = 8,
    parameter int TW       = 10
);
    localparam int AW = $clog2(NUM_REGS);

    logic          AccValid;
    logic [DW-1:0] AccData;
    logic          AccReady;
    logic          GenValid;
    logic [AW-1:0] GenAddr;
    logic [DW-1:0] GenData;
    logic          GenReady;
    logic          BrValid;
    logic [TW-1:0] BrTarget;
    logic          BrReady;
    logic          WriteR0;
    logic          GenRegWrite;
    logic          LUTsignal;
    logic [AW-1:0] WAddr;
    logic [DW-1:0] DataIn;
    logic [TW-1:0] Target;
    logic          InitDone;

    modport slave (
        input  AccValid, AccData, GenValid, GenAddr, GenData, BrValid, BrTarget,
        output AccReady, GenReady, BrReady,
        output WriteR0, GenRegWrite, LUTsignal, WAddr, DataIn, Target, InitDone
    );

    modport master (
        output AccValid, AccData, GenValid, GenAddr, GenData, BrValid, BrTarget,
        input  AccReady, GenReady, BrReady,
        input  WriteR0, GenRegWrite, LUTsignal, WAddr, DataIn, Target, InitDone
    );

endinterface

// File: rtl/rf_sched_arb.sv
// Three-way combinational grant; round-robin when RF_WRITE_SCHED_RR_EN is defined,
// otherwise fixed BR > ACC > GEN.
module rf_sched_arb
    import rf_sched_pkg::*;
(
    input  logic               en,
    input  logic [NUM_REQ-1:0] valid,
`ifdef RF_WRITE_SCHED_RR_EN
    input  req_id_t            ptr,
`endif
    output logic [NUM_REQ-1:0] grant
);

`ifdef RF_WRITE_SCHED_RR_EN
    logic found;
    int   idx;

    // Search starts just after the last winner, so it becomes lowest priority.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (en && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        if (en) begin
            if (valid[REQ_BR])       grant[REQ_BR]  = 1'b1;
            else if (valid[REQ_ACC]) grant[REQ_ACC] = 1'b1;
            else if (valid[REQ_GEN]) grant[REQ_GEN] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: post-reset clear sweep, then one producer
// write per cycle. Define RF_WRITE_SCHED_RR_EN for round-robin arbitration.
module rf_write_sched
    import rf_sched_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int DW         = DW_DEF,
    parameter int TW         = TW_DEF,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    rf_write_sched_if.slave  bus
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);
    localparam logic [CW-1:0] SWEEP_LAST = CW'(NUM_REGS);

    sched_state_t       state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wr0_q, wr0_d;
    logic               gen_q, gen_d;
    logic               lut_q, lut_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [DW-1:0]      data_q, data_d;
    logic [TW-1:0]      target_q, target_d;
    logic               init_done_q, init_done_d;
    logic [NUM_REQ-1:0] valid, grant;

    assign valid = {bus.GenValid, bus.AccValid, bus.BrValid};

`ifdef RF_WRITE_SCHED_RR_EN
    req_id_t ptr_q, ptr_d;

    rf_sched_arb u_arb (
        .en    (state_q == ARB),
        .valid (valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (grant[REQ_BR])       ptr_d = REQ_BR;
        else if (grant[REQ_ACC]) ptr_d = REQ_ACC;
        else if (grant[REQ_GEN]) ptr_d = REQ_GEN;
    end

    always_ff @(posedge Clk) begin
        if (Reset) ptr_q <= REQ_BR;
        else       ptr_q <= ptr_d;
    end
`else
    rf_sched_arb u_arb (
        .en    (state_q == ARB),
        .valid (valid),
        .grant (grant)
    );
`endif

    assign bus.BrReady  = grant[REQ_BR];
    assign bus.AccReady = grant[REQ_ACC];
    assign bus.GenReady = grant[REQ_GEN];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr0_d       = 1'b0;
        gen_d       = 1'b0;
        lut_d       = 1'b0;
        waddr_d     = waddr_q;
        data_d      = data_q;
        target_d    = target_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    wr0_d   = 1'b1;
                    waddr_d = '0;
                    data_d  = '0;
                end else if (cnt_q < SWEEP_LAST) begin
                    gen_d   = 1'b1;
                    waddr_d = cnt_q[AW-1:0];
                    data_d  = '0;
                end else begin
                    lut_d       = 1'b1;
                    target_d    = '0;
                    state_d     = ARB;
                    init_done_d = 1'b1;
                end
            end
            ARB: begin
                if (grant[REQ_BR]) begin
                    lut_d    = 1'b1;
                    target_d = bus.BrTarget;
                end else if (grant[REQ_ACC]) begin
                    wr0_d   = 1'b1;
                    waddr_d = '0;
                    data_d  = bus.AccData;
                end else if (grant[REQ_GEN]) begin
                    // R0 is only ever written through the WriteR0 strobe.
                    if (bus.GenAddr == '0) wr0_d = 1'b1;
                    else                   gen_d = 1'b1;
                    waddr_d = bus.GenAddr;
                    data_d  = bus.GenData;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= INIT_CLEAR ? INIT : ARB;
            init_done_q <= !INIT_CLEAR;
            cnt_q       <= '0;
            wr0_q       <= 1'b0;
            gen_q       <= 1'b0;
            lut_q       <= 1'b0;
            waddr_q     <= '0;
            data_q      <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            cnt_q       <= cnt_d;
            wr0_q       <= wr0_d;
            gen_q       <= gen_d;
            lut_q       <= lut_d;
            waddr_q     <= waddr_d;
            data_q      <= data_d;
            target_q    <= target_d;
        end
    end

    assign bus.WriteR0     = wr0_q;
    assign bus.GenRegWrite = gen_q;
    assign bus.LUTsignal   = lut_q;
    assign bus.WAddr       = waddr_q;
    assign bus.DataIn      = data_q;
    assign bus.Target      = target_q;
    assign bus.InitDone    = init_done_q;

endmodule

// File: tb/tb_rf_write_sched.sv
// Scoreboard bench for rf_write_sched: stimulus pushes expected strobes, a
// monitor pops and compares each strobe cycle.
module tb_rf_write_sched;

    localparam int NUM_REGS = 16;
    localparam int DW       = 8;
    localparam int TW       = 10;

    typedef struct packed {
        logic       wr0;
        logic       gen;
        logic       lut;
        logic [3:0] waddr;
        logic [7:0] data;
        logic [9:0] target;
    } item_t;

    logic  Clk;
    logic  Reset;
    int    checks   = 0;
    int    failures = 0;
    item_t exp_q[$];

    rf_write_sched_if #(.NUM_REGS(NUM_REGS), .DW(DW), .TW(TW)) bus ();

    rf_write_sched #(.NUM_REGS(NUM_REGS), .DW(DW), .TW(TW), .INIT_CLEAR(1'b1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic w, input logic g, input logic l,
                                 input logic [3:0] a, input logic [7:0] d, input logic [9:0] t);
        return {w, g, l, a, d, t};
    endfunction

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 0)             exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 10'd0));
            else if (i < NUM_REGS)  exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'(i), 8'd0, 10'd0));
            else                    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'd15, 8'd0, 10'd0));
        end
    endtask

    // Monitor: every strobe cycle consumes one expected item.
    initial begin
        item_t act, e;
        @(posedge Clk);
        forever begin
            @(negedge Clk);
            chk("strobe_onehot0", 32'($onehot0({bus.WriteR0, bus.GenRegWrite, bus.LUTsignal})), 32'd1);
            chk("ready_onehot0", 32'($onehot0({bus.AccReady, bus.GenReady, bus.BrReady})), 32'd1);
            if (bus.WriteR0 || bus.GenRegWrite || bus.LUTsignal) begin
                act = {bus.WriteR0, bus.GenRegWrite, bus.LUTsignal, bus.WAddr, bus.DataIn, bus.Target};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=%0h expected=none @%0t", act, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_item", 32'(act), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rdy;
        logic [2:0] exp_rdy[3];
        logic       bf, af, gf;
        int         n;

        Reset        = 1'b1;
        bus.AccValid = 1'b1; bus.AccData  = 8'd13;
        bus.GenValid = 1'b1; bus.GenAddr  = 4'd5; bus.GenData = 8'h7E;
        bus.BrValid  = 1'b1; bus.BrTarget = 10'd255;

        // Reset state, with all producers requesting.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_strobes", 32'({bus.WriteR0, bus.GenRegWrite, bus.LUTsignal}), 32'd0);
        chk("rst_waddr", 32'(bus.WAddr), 32'd0);
        chk("rst_data", 32'(bus.DataIn), 32'd0);
        chk("rst_target", 32'(bus.Target), 32'd0);
        chk("rst_init_done", 32'(bus.InitDone), 32'd0);
        chk("rst_ready", 32'({bus.BrReady, bus.AccReady, bus.GenReady}), 32'd0);
        repeat (3) @(posedge Clk);
        #1;

        push_sweep(NUM_REGS + 1);
`ifdef RF_WRITE_SCHED_RR_EN
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 8'd13, 10'd0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'd5, 8'h7E, 10'd0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'd5, 8'h7E, 10'd255));
        exp_rdy[0] = 3'b010; exp_rdy[1] = 3'b001; exp_rdy[2] = 3'b100;
`else
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'd15, 8'd0, 10'd255));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 8'd13, 10'd255));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'd5, 8'h7E, 10'd255));
        exp_rdy[0] = 3'b100; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b001;
`endif
        Reset = 1'b0;

        // Clear sweep: no Ready and no InitDone for 17 cycles.
        for (int k = 0; k < NUM_REGS + 1; k++) begin
            @(negedge Clk);
            chk("sweep_ready", 32'({bus.BrReady, bus.AccReady, bus.GenReady}), 32'd0);
            chk("sweep_init_done", 32'(bus.InitDone), 32'd0);
            @(posedge Clk); #1;
        end

        // Three-way contention, producers drop Valid once accepted.
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            if (k == 0) chk("init_done_set", 32'(bus.InitDone), 32'd1);
            rdy = {bus.BrReady, bus.AccReady, bus.GenReady};
            chk("contend_ready", 32'(rdy), 32'(exp_rdy[k]));
            bf = bus.BrValid && bus.BrReady;
            af = bus.AccValid && bus.AccReady;
            gf = bus.GenValid && bus.GenReady;
            @(posedge Clk); #1;
            if (bf) bus.BrValid  = 1'b0;
            if (af) bus.AccValid = 1'b0;
            if (gf) bus.GenValid = 1'b0;
        end
        @(negedge Clk);
        chk("contend_drained_ready", 32'({bus.BrReady, bus.AccReady, bus.GenReady}), 32'd0);

        // GEN write to R0 goes out on WriteR0.
        @(posedge Clk); #1;
        bus.GenValid = 1'b1; bus.GenAddr = 4'd0; bus.GenData = 8'h42;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 8'h42, 10'd255));
        @(negedge Clk);
        chk("gen_r0_ready", 32'(bus.GenReady), 32'd1);
        @(posedge Clk); #1;
        bus.GenValid = 1'b0;
        @(negedge Clk);
        chk("gen_r0_genregwrite", 32'(bus.GenRegWrite), 32'd0);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("idle_strobes", 32'({bus.WriteR0, bus.GenRegWrite, bus.LUTsignal}), 32'd0);
        chk("idle_waddr_hold", 32'(bus.WAddr), 32'd0);
        chk("idle_data_hold", 32'(bus.DataIn), 32'h42);

        // ACC held continuously against GEN.
        @(posedge Clk); #1;
        bus.AccValid = 1'b1; bus.AccData = 8'h11;
        bus.GenValid = 1'b1; bus.GenAddr = 4'd3; bus.GenData = 8'h33;
        for (int k = 0; k < 8; k++) begin
`ifdef RF_WRITE_SCHED_RR_EN
            if (k % 2 == 0) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 8'h11, 10'd255));
            else            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'd3, 8'h33, 10'd255));
`else
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 8'h11, 10'd255));
`endif
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
`ifdef RF_WRITE_SCHED_RR_EN
            chk("starve_gen_ready", 32'(bus.GenReady), 32'(k % 2));
`else
            chk("starve_gen_ready", 32'(bus.GenReady), 32'd0);
`endif
            @(posedge Clk); #1;
        end
        bus.AccValid = 1'b0; bus.GenValid = 1'b0;
        @(negedge Clk);

        // Reset at sweep count 7 restarts the sweep from 0.
        @(posedge Clk); #1;
        Reset = 1'b1;
        push_sweep(7);
        push_sweep(NUM_REGS + 1);
        repeat (2) begin @(posedge Clk); #1; end
        Reset = 1'b0;
        repeat (7) begin @(posedge Clk); #1; end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("midreset_strobes", 32'({bus.WriteR0, bus.GenRegWrite, bus.LUTsignal}), 32'd0);
        chk("midreset_waddr", 32'(bus.WAddr), 32'd0);
        chk("midreset_init_done", 32'(bus.InitDone), 32'd0);
        n = 0;
        while (!bus.InitDone && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("restart_sweep_len", 32'(n), 32'(NUM_REGS + 1));
        @(negedge Clk);
        @(posedge Clk); #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
